// File: rtl/pc_gen_if.sv
// Bundle of the PC generator's control inputs and PC outputs.
//   master: drives stall/branch/halt controls, observes PC state (core control / bench)
//   slave : the PC generator itself
interface pc_gen_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 3
);
  logic                      stall;
  logic                      branch_taken;
  logic [WIDTH-1:0]          branch_target;
  logic                      halt_dec;
  logic [WIDTH-1:0]          pc;
  logic [WIDTH-1:0]          pc_plus;
  logic [STAGES*WIDTH-1:0]   pc_pipe;
  logic [STAGES-1:0]         pc_pipe_vld;
  logic                      halted;

  modport master (
    output stall, branch_taken, branch_target, halt_dec,
    input  pc, pc_plus, pc_pipe, pc_pipe_vld, halted
  );

  modport slave (
    input  stall, branch_taken, branch_target, halt_dec,
    output pc, pc_plus, pc_pipe, pc_pipe_vld, halted
  );
endinterface

// File: rtl/pc_gen_pipe.sv
// Program-counter generator for the pipelined core.
// Produces the fetch PC with stall / branch redirect, carries PC copies with
// valid bits down STAGES pipe stages, and runs a halt sequence that drains the
// pipe for STAGES cycles before freezing everything.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_gen_if slave (stall, branch_taken, branch_target, halt_dec in;
//                pc, pc_plus, pc_pipe, pc_pipe_vld, halted out)
module pc_gen_pipe #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned INC      = 2,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned STAGES   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  pc_gen_if.slave     bus
);

  localparam int unsigned CNT_W = $clog2(STAGES + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [CNT_W-1:0]              drain_cnt_q, drain_cnt_d;
  logic [WIDTH-1:0]              pc_q, pc_d;
  logic [STAGES-1:0][WIDTH-1:0]  pipe_q, pipe_d;
  logic [STAGES-1:0]             vld_q, vld_d;
  logic                          halted_q, halted_d;
  logic                          stall_bubble;

  // A stall only matters while running; it holds stage 0 and sends a bubble into stage 1.
  assign stall_bubble = (state_q == ST_RUN) && bus.stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      pc_q        <= WIDTH'(RESET_PC);
      pipe_q      <= '0;
      vld_q       <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      pc_q        <= pc_d;
      pipe_q      <= pipe_d;
      vld_q       <= vld_d;
      halted_q    <= halted_d;
    end
  end

  // Next-state, next-PC and pipe-copy logic
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_d        = pc_q;
    pipe_d      = pipe_q;
    vld_d       = vld_q;
    halted_d    = halted_q;

    // Downstream stages shift unconditionally; overridden below when HALTED.
    for (int i = 1; i < int'(STAGES); i++) begin
      pipe_d[i] = pipe_q[i-1];
      vld_d[i]  = (i == 1) ? (vld_q[i-1] & ~stall_bubble) : vld_q[i-1];
    end

    unique case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          pipe_d[0] = pc_q;
          vld_d[0]  = 1'b1;
        end
        if (bus.branch_taken) begin
          // Redirect wins over stall and over a same-cycle halt (wrong-path HLT).
          pc_d     = bus.branch_target;
          vld_d[0] = 1'b0;
        end else if (bus.halt_dec) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = CNT_W'(STAGES);
        end else if (!bus.stall) begin
          pc_d = pc_q + WIDTH'(INC);
        end
      end

      ST_DRAIN: begin
        vld_d[0]    = 1'b0;
        drain_cnt_d = drain_cnt_q - CNT_W'(1);
        if (bus.branch_taken) begin
          pc_d        = bus.branch_target;
          drain_cnt_d = '0;
          state_d     = ST_RUN;
        end else if (drain_cnt_q == CNT_W'(1)) begin
          state_d = ST_HALTED;
        end
      end

      ST_HALTED: begin
        pipe_d = pipe_q;
        vld_d  = '0;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    halted_d = (state_d == ST_HALTED);
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus     = pc_q + WIDTH'(INC);
  assign bus.pc_pipe     = pipe_q;
  assign bus.pc_pipe_vld = vld_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_gen_pipe.sv
// Bench for pc_gen_pipe: directed vector table, hand-written halt / reset
// sequences, then random stimulus against a queue-based reference model.
module tb_pc_gen_pipe;

  localparam int unsigned W   = 16;
  localparam int unsigned S   = 3;
  localparam int unsigned INC = 2;

  logic clk;
  logic rst_n;

  pc_gen_if #(.WIDTH(W), .STAGES(S)) bus ();

  pc_gen_pipe #(.WIDTH(W), .INC(INC), .RESET_PC(0), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: fetch PC, pipe as a queue (front = stage 0), mode 0 run / 1 drain / 2 halted
  int unsigned m_pc;
  int unsigned m_cp[$];
  bit          m_v[$];
  int          m_mode;
  int          m_left;

  function automatic void model_reset();
    m_pc = 0;
    m_cp.delete();
    m_v.delete();
    for (int i = 0; i < int'(S); i++) begin
      m_cp.push_back(0);
      m_v.push_back(1'b0);
    end
    m_mode = 0;
    m_left = 0;
  endfunction

  function automatic void model_step(bit st, bit br, int unsigned tgt, bit hlt);
    int unsigned n_cp;
    bit          n_v;
    bit          bubble;
    bubble = 1'b0;
    n_cp   = 0;
    n_v    = 1'b0;
    if (m_mode == 2) begin
      for (int i = 0; i < int'(S); i++) m_v[i] = 1'b0;
      return;
    end
    if (m_mode == 0) begin
      if (st) begin
        n_cp   = m_cp[0];
        n_v    = m_v[0];
        bubble = 1'b1;
      end else begin
        n_cp = m_pc;
        n_v  = 1'b1;
      end
      if (br) begin
        n_v  = 1'b0;
        m_pc = tgt;
      end else if (hlt) begin
        m_mode = 1;
        m_left = int'(S);
      end else if (!st) begin
        m_pc = (m_pc + INC) % 65536;
      end
    end else begin
      n_cp = m_cp[0];
      n_v  = 1'b0;
      if (br) begin
        m_pc   = tgt;
        m_mode = 0;
      end else if (m_left == 1) begin
        m_mode = 2;
      end else begin
        m_left--;
      end
    end
    if (bubble) m_v[0] = 1'b0;
    m_cp.push_front(n_cp);
    m_v.push_front(n_v);
    void'(m_cp.pop_back());
    void'(m_v.pop_back());
  endfunction

  function automatic logic [S*W-1:0] exp_pipe();
    logic [S*W-1:0] e;
    e = '0;
    for (int i = 0; i < int'(S); i++) e[i*W +: W] = W'(m_cp[i]);
    return e;
  endfunction

  function automatic logic [S-1:0] exp_vld();
    logic [S-1:0] e;
    e = '0;
    for (int i = 0; i < int'(S); i++) e[i] = m_v[i];
    return e;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_model(string tag);
    chk({tag, ".pc"},      64'(bus.pc),          64'(W'(m_pc)));
    chk({tag, ".pc_plus"}, 64'(bus.pc_plus),     64'(W'((m_pc + INC) % 65536)));
    chk({tag, ".pipe"},    64'(bus.pc_pipe),     64'(exp_pipe()));
    chk({tag, ".vld"},     64'(bus.pc_pipe_vld), 64'(exp_vld()));
    chk({tag, ".halted"},  64'(bus.halted),      64'(m_mode == 2));
  endfunction

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later.
  task automatic cycle(input bit st, input bit br, input logic [W-1:0] tgt, input bit hlt,
                       input string tag);
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.halt_dec      = hlt;
    @(posedge clk);
    model_step(st, br, int'(tgt), hlt);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset asserted and released away from the clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_pc"},     64'(bus.pc), 64'h0);
    chk({tag, ".rst_vld"},    64'(bus.pc_pipe_vld), 64'h0);
    chk({tag, ".rst_halted"}, 64'(bus.halted), 64'h0);
    check_model({tag, ".rst"});
    #2;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit           st;
    bit           br;
    logic [W-1:0] tgt;
    bit           hlt;
    logic [W-1:0] e_pc;
    logic [S-1:0] e_vld;
    logic [W-1:0] e_s2;
    bit           e_halt;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // Expected values after each edge; e_vld is {stage2, stage1, stage0}.
    vecs[0]  = '{0, 0, 16'h0000, 0, 16'h0002, 3'b001, 16'h0000, 0};
    vecs[1]  = '{0, 0, 16'h0000, 0, 16'h0004, 3'b011, 16'h0000, 0};
    vecs[2]  = '{0, 0, 16'h0000, 0, 16'h0006, 3'b111, 16'h0000, 0};
    vecs[3]  = '{0, 0, 16'h0000, 0, 16'h0008, 3'b111, 16'h0002, 0};
    vecs[4]  = '{0, 1, 16'h000E, 0, 16'h000E, 3'b110, 16'h0004, 0};
    vecs[5]  = '{0, 0, 16'h0000, 0, 16'h0010, 3'b101, 16'h0006, 0};
    vecs[6]  = '{1, 0, 16'h0000, 0, 16'h0010, 3'b001, 16'h0008, 0};
    vecs[7]  = '{1, 0, 16'h0000, 0, 16'h0010, 3'b001, 16'h000E, 0};
    vecs[8]  = '{1, 1, 16'h0040, 0, 16'h0040, 3'b000, 16'h000E, 0};
    vecs[9]  = '{0, 0, 16'h0000, 0, 16'h0042, 3'b001, 16'h000E, 0};
    vecs[10] = '{0, 1, 16'hFFFC, 0, 16'hFFFC, 3'b010, 16'h000E, 0};
    vecs[11] = '{0, 0, 16'h0000, 0, 16'hFFFE, 3'b101, 16'h0040, 0};
    vecs[12] = '{0, 0, 16'h0000, 0, 16'h0000, 3'b011, 16'h0042, 0};
    vecs[13] = '{0, 0, 16'h0000, 0, 16'h0002, 3'b111, 16'hFFFC, 0};
    vecs[14] = '{0, 1, 16'h0080, 1, 16'h0080, 3'b110, 16'hFFFE, 0};
    vecs[15] = '{0, 0, 16'h0000, 0, 16'h0082, 3'b101, 16'h0000, 0};
    vecs[16] = '{0, 0, 16'h0000, 1, 16'h0082, 3'b011, 16'h0002, 0};
    vecs[17] = '{0, 1, 16'h0080, 0, 16'h0080, 3'b110, 16'h0080, 0};
    vecs[18] = '{0, 0, 16'h0000, 0, 16'h0082, 3'b101, 16'h0082, 0};

    rst_n             = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.halt_dec      = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    chk("reset.pc_plus", 64'(bus.pc_plus), 64'h2);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: free run, pipe latency, stall bubbles, stall+branch, wrap, halt cancel
    for (int k = 0; k < 19; k++) begin
      cycle(vecs[k].st, vecs[k].br, vecs[k].tgt, vecs[k].hlt, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d.tbl_pc", k),  64'(bus.pc),               64'(vecs[k].e_pc));
      chk($sformatf("vec%0d.tbl_vld", k), 64'(bus.pc_pipe_vld),      64'(vecs[k].e_vld));
      chk($sformatf("vec%0d.tbl_s2", k),  64'(bus.pc_pipe[2*W +: W]), 64'(vecs[k].e_s2));
      chk($sformatf("vec%0d.tbl_hlt", k), 64'(bus.halted),           64'(vecs[k].e_halt));
    end

    // Halt at 0x20: frozen PC, halted after STAGES drain cycles, then immune to stall/branch
    cycle(0, 1, 16'h0020, 0, "halt.br");
    cycle(0, 0, 16'h0000, 1, "halt.dec");
    chk("halt.frozen_pc", 64'(bus.pc), 64'h20);
    for (int k = 1; k <= int'(S); k++) begin
      cycle(0, 0, 16'h0000, 0, $sformatf("drain%0d", k));
      chk($sformatf("drain%0d.pc", k),     64'(bus.pc),     64'h20);
      chk($sformatf("drain%0d.halted", k), 64'(bus.halted), 64'(k == int'(S)));
    end
    chk("halted.vld", 64'(bus.pc_pipe_vld), 64'h0);
    for (int k = 0; k < 6; k++) begin
      cycle(k[0], k[1] | k[2], 16'h0100, k[0], $sformatf("frozen%0d", k));
      chk($sformatf("frozen%0d.pc", k),     64'(bus.pc),     64'h20);
      chk($sformatf("frozen%0d.halted", k), 64'(bus.halted), 64'h1);
      chk($sformatf("frozen%0d.vld", k),    64'(bus.pc_pipe_vld), 64'h0);
    end

    // Mid-cycle async reset out of HALTED, then count 0,2,4,6
    async_reset("midrst");
    chk("midrst.pc0", 64'(bus.pc), 64'h0);
    for (int k = 1; k <= 3; k++) begin
      cycle(0, 0, 16'h0000, 0, $sformatf("post%0d", k));
      chk($sformatf("post%0d.pc", k), 64'(bus.pc), 64'(2 * k));
    end

    // Random stimulus against the model, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      bit           st;
      bit           br;
      bit           hl;
      logic [W-1:0] tg;
      st = ($urandom_range(99) < 30);
      br = ($urandom_range(99) < 10);
      hl = ($urandom_range(99) < 4);
      tg = W'($urandom) & 16'hFFFE;
      if ((m_mode == 2 && $urandom_range(7) == 0) || $urandom_range(499) == 0) begin
        async_reset($sformatf("rnd%0d", n));
      end else begin
        cycle(st, br, tg, hl, $sformatf("rnd%0d", n));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
